concat_ddr_sched: RTL

- Parametrised successor to the fixed 6-channel skip-connection concat scheduler.
- Arbitrates the DDR port between two sides: CH_NUM encoder skip FIFOs flushing bursts to DDR, and CH_NUM decoder skip FIFOs refilling from DDR.
- Each channel owns a circular burst region in DDR.
- The block tracks per-channel write/read pointers and occupancy, generates burst addresses, and issues one-hot per-beat FIFO strobes.

---
 rtl/concat_ddr_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/concat_ddr_sched.sv
// Skip-connection concat scheduler: arbitrates one DDR port between encoder FIFO flushes and decoder FIFO refills.
// Optional macro CONCAT_RW_ALT_EN: alternate read/write direction on ties instead of always favouring reads.
module concat_ddr_sched #(
  parameter int CH_NUM        = 6,
  parameter int BURST_LEN     = 16,
  parameter int REGION_BURSTS = 64,
  parameter int ADDR_WIDTH    = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CH_NUM-1:0]     req_wr,
  input  logic [CH_NUM-1:0]     req_rd,
  input  logic                  frame_start,
  output logic                  ddr_cmd_valid,
  output logic                  ddr_cmd_wr,
  output logic [ADDR_WIDTH-1:0] ddr_cmd_addr,
  input  logic                  ddr_cmd_ready,
  input  logic                  ddr_beat,
  output logic [CH_NUM-1:0]     ddr_fifo_rd,
  output logic [CH_NUM-1:0]     ddr_fifo_wr,
  output logic                  busy,
  output logic [CH_NUM-1:0]     region_full
);

  localparam int unsigned NCH = CH_NUM;
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PW = $clog2(REGION_BURSTS);
  localparam int OW = PW + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [OW-1:0] OCC_FULL  = OW'(REGION_BURSTS);
  localparam logic [CW-1:0] CH_LAST   = CW'(CH_NUM - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state, state_n;
  logic [PW-1:0]         wp [CH_NUM];
  logic [PW-1:0]         wp_n [CH_NUM];
  logic [PW-1:0]         rp [CH_NUM];
  logic [PW-1:0]         rp_n [CH_NUM];
  logic [OW-1:0]         occ [CH_NUM];
  logic [OW-1:0]         occ_n [CH_NUM];
  logic [CW-1:0]         wr_rr, wr_rr_n, rd_rr, rd_rr_n;
  logic [BW-1:0]         beat_cnt, beat_cnt_n;
  logic                  pend_clr, pend_clr_n;
  logic [CW-1:0]         g_ch, g_ch_n;
  logic                  g_wr, g_wr_n;
  logic [ADDR_WIDTH-1:0] g_addr, g_addr_n;
  logic [CH_NUM-1:0]     elig_wr, elig_rd, g_onehot;
  logic                  wr_found, rd_found, pick_wr;
  logic [CW-1:0]         wr_pick, rd_pick;
`ifdef CONCAT_RW_ALT_EN
  logic                  last_wr, last_wr_n;
`endif

  // Returns {found, channel}: first eligible channel scanning upward from start, wrapping.
  function automatic logic [CW:0] rr_pick(input logic [CH_NUM-1:0] elig,
                                          input logic [CW-1:0]     start);
    logic [CW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = i + 32'(start);
      if (idx >= NCH) idx = idx - NCH;
      if (!res[CW] && elig[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] ch);
    return (ch == CH_LAST) ? '0 : ch + 1'b1;
  endfunction

  // Region sizes are powers of two, so the address is a plain field concatenation.
  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [CW-1:0] ch,
                                                       input logic [PW-1:0] ptr);
    return (ADDR_WIDTH'(ch) << (PW + BW)) | (ADDR_WIDTH'(ptr) << BW);
  endfunction

  always_comb begin
    elig_wr = '0;
    elig_rd = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      elig_wr[c] = req_wr[c] && (occ[c] != OCC_FULL);
      elig_rd[c] = req_rd[c] && (occ[c] != '0);
    end
    {wr_found, wr_pick} = rr_pick(elig_wr, wr_rr);
    {rd_found, rd_pick} = rr_pick(elig_rd, rd_rr);
`ifdef CONCAT_RW_ALT_EN
    pick_wr = wr_found && (!rd_found || !last_wr);
`else
    pick_wr = wr_found && !rd_found;
`endif
  end

  always_comb begin
    state_n    = state;
    wp_n       = wp;
    rp_n       = rp;
    occ_n      = occ;
    wr_rr_n    = wr_rr;
    rd_rr_n    = rd_rr;
    beat_cnt_n = beat_cnt;
    pend_clr_n = pend_clr;
    g_ch_n     = g_ch;
    g_wr_n     = g_wr;
    g_addr_n   = g_addr;
`ifdef CONCAT_RW_ALT_EN
    last_wr_n  = last_wr;
`endif
    case (state)
      IDLE: begin
        if (pend_clr || frame_start) begin
          for (int unsigned c = 0; c < NCH; c++) begin
            wp_n[c]  = '0;
            rp_n[c]  = '0;
            occ_n[c] = '0;
          end
          wr_rr_n    = '0;
          rd_rr_n    = '0;
          pend_clr_n = 1'b0;
        end else if (wr_found || rd_found) begin
          g_wr_n   = pick_wr;
          g_ch_n   = pick_wr ? wr_pick : rd_pick;
          g_addr_n = pick_wr ? burst_addr(wr_pick, wp[wr_pick])
                             : burst_addr(rd_pick, rp[rd_pick]);
          state_n  = CMD;
        end
      end
      CMD: begin
        if (frame_start) pend_clr_n = 1'b1;
        if (ddr_cmd_ready) begin
          beat_cnt_n = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (frame_start) pend_clr_n = 1'b1;
        if (ddr_beat) begin
          beat_cnt_n = beat_cnt + 1'b1;
          if (beat_cnt == BEAT_LAST) begin
            state_n = IDLE;
`ifdef CONCAT_RW_ALT_EN
            last_wr_n = g_wr;
`endif
            // A pending clear wipes everything in IDLE, so skipping the update keeps region_full glitch-free.
            if (!(pend_clr || frame_start)) begin
              if (g_wr) begin
                wp_n[g_ch]  = wp[g_ch] + 1'b1;
                occ_n[g_ch] = occ[g_ch] + 1'b1;
                wr_rr_n     = rr_next(g_ch);
              end else begin
                rp_n[g_ch]  = rp[g_ch] + 1'b1;
                occ_n[g_ch] = occ[g_ch] - 1'b1;
                rd_rr_n     = rr_next(g_ch);
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      for (int unsigned c = 0; c < NCH; c++) begin
        wp[c]  <= '0;
        rp[c]  <= '0;
        occ[c] <= '0;
      end
      wr_rr       <= '0;
      rd_rr       <= '0;
      beat_cnt    <= '0;
      pend_clr    <= 1'b0;
      g_ch        <= '0;
      g_wr        <= 1'b0;
      g_addr      <= '0;
      region_full <= '0;
`ifdef CONCAT_RW_ALT_EN
      last_wr     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      wp       <= wp_n;
      rp       <= rp_n;
      occ      <= occ_n;
      wr_rr    <= wr_rr_n;
      rd_rr    <= rd_rr_n;
      beat_cnt <= beat_cnt_n;
      pend_clr <= pend_clr_n;
      g_ch     <= g_ch_n;
      g_wr     <= g_wr_n;
      g_addr   <= g_addr_n;
      for (int unsigned c = 0; c < NCH; c++) begin
        region_full[c] <= (occ_n[c] == OCC_FULL);
      end
`ifdef CONCAT_RW_ALT_EN
      last_wr  <= last_wr_n;
`endif
    end
  end

  always_comb begin
    g_onehot      = CH_NUM'(1) << g_ch;
    busy          = (state != IDLE);
    ddr_cmd_valid = (state == CMD);
    ddr_cmd_wr    = g_wr;
    ddr_cmd_addr  = g_addr;
    ddr_fifo_rd   = (state == DATA && g_wr)  ? (g_onehot & {CH_NUM{ddr_beat}}) : '0;
    ddr_fifo_wr   = (state == DATA && !g_wr) ? (g_onehot & {CH_NUM{ddr_beat}}) : '0;
  end

endmodule
